can_tx_bit_stuffer: RTL and testbench
=====================================

Name: can_tx_bit_stuffer

Overview:
CAN transmit-side bit serializer. It accepts one frame bit at a time from the frame builder over a valid/ready handshake and drives the TX pin for exactly one nominal bit period per bit. It inserts complementary stuff bits after five identical consecutive bits while stuffing is enabled. It sits between the TX frame builder and the transceiver TXD pin, and mirrors the RX mid-bit sampler on the receive side.

Parameters:
clk_speed_MHz, 100, system clock frequency in MHz
can_bit_rate_Kbits, 1000, CAN bit rate in kbit/s
CLKS_PER_BIT (localparam), (clk_speed_MHz*1000)/can_bit_rate_Kbits, clocks per bit (100 at defaults)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
en  in  1  frame active; high from SOF through end of frame
stuff_en  in  1  stuffing region active (SOF through CRC sequence); sampled at bit boundaries
din  in  1  next frame bit (0 = dominant)
din_valid  in  1  din holds a valid bit
din_ready  out  1  block accepts din this cycle; combinational
tx  out  1  registered TXD line
bit_strobe  out  1  one-cycle pulse in the first cycle of every transmitted bit (data or stuff)
stuff_active  out  1  high for the whole period of a stuff bit
underrun  out  1  one-cycle pulse when en is high at a bit boundary but din_valid is low

Behaviour:
- Reset values (async): tx=1 (recessive), bit_strobe=0, stuff_active=0, underrun=0, state=IDLE, bit counter=0, run_len=0, last_bit=1.
- Bit counter counts 0..CLKS_PER_BIT-1 in DATA and STUFF. A "boundary" is the cycle with counter==CLKS_PER_BIT-1.
- IDLE:
  - din_ready = en.
  - On din_valid&&din_ready: next cycle tx=din, bit_strobe=1, counter=0, state=DATA, last_bit=din, run_len=1.
- DATA/STUFF: tx holds its value for exactly CLKS_PER_BIT cycles. din_ready=0 except at a boundary with no stuff pending.
- Stuff pending: run_len==5 && stuff_en && en, evaluated at the boundary.
- At each boundary, the first matching case applies:
  - Stuff pending: next cycle state=STUFF, tx=~last_bit, stuff_active=1, bit_strobe=1, last_bit=~last_bit, run_len=1. din_ready=0.
  - en low: next cycle state=IDLE, tx=1. Any pending stuff bit is dropped.
  - en high with handshake: next cycle state=DATA, tx=din, bit_strobe=1, stuff_active=0. If din==last_bit and stuff_en, run_len+1; otherwise run_len=1 and last_bit=din.
  - en high without din_valid: next cycle underrun=1, state=IDLE, tx=1.
- Stuff bits count toward the run. Five identical bits after a stuff bit trigger a new stuff bit.
- With stuff_en low at a load, run_len resets to 1, so no stuff bit is inserted; counting resumes only once stuff_en returns.
- en falling mid-bit: the current bit completes its full period, then the block returns to IDLE. tx is never truncated.
- run_len is 3 bits and saturates at 5.
- Bit-period latency: first tx edge is 1 clock after the IDLE handshake. Successive bits are exactly CLKS_PER_BIT clocks apart.
- Async reset mid-bit forces tx=1 immediately and clears all state.

Test Plan:
- Reset: assert rst_n=0 mid-transmission with tx=0 -> tx=1 immediately; after release with en=0, din_ready=0, bit_strobe=0, underrun=0.
- Bits 0,1,0 with din_valid held, en=1, stuff_en=1 -> tx=0/1/0, each exactly 100 clocks; bit_strobe pulses 100 clocks apart; no stuff_active; din_ready high only at IDLE start and boundaries.
- Five 0s then 1, stuff_en=1 -> sixth slot tx=1 with stuff_active=1 for 100 cycles and din_ready=0 at that boundary; the data 1 follows in slot 7 (700 clocks total).
- 0,0,0,0,0 then 1,1,1,1 -> stuff 1 after the fifth 0, then a stuff 0 immediately after the fourth data 1 (stuff bit counted in the run).
- Seven 0s with stuff_en=0 -> no stuff bits; tx=0 for 700 clocks; stuff_active never high.
- en=1, din_valid dropped before the third boundary -> underrun pulses once, tx returns to 1 next cycle, state IDLE; din_ready=1 again while en=1.

Source files
------------

// File: rtl/can_tx_bit_stuffer.sv
// CAN transmit bit serializer: one frame bit per nominal bit period on the TXD line, inserting
// complementary stuff bits after five identical consecutive bits while stuffing is enabled.
module can_tx_bit_stuffer #(
    parameter int unsigned clk_speed_MHz      = 100,
    parameter int unsigned can_bit_rate_Kbits = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic stuff_en,
    input  logic din,
    input  logic din_valid,
    output logic din_ready,
    output logic tx,
    output logic bit_strobe,
    output logic stuff_active,
    output logic underrun
);

    localparam int unsigned CLKS_PER_BIT = (clk_speed_MHz * 1000) / can_bit_rate_Kbits;
    localparam int unsigned CntW         = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] CntMax   = CntW'(CLKS_PER_BIT - 1);
    localparam logic [2:0] StuffRun      = 3'd5;

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StStuff
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      run_len_q, run_len_d;
    logic            last_bit_q, last_bit_d;
    logic            tx_q, tx_d;
    logic            bit_strobe_q, bit_strobe_d;
    logic            stuff_active_q, stuff_active_d;
    logic            underrun_q, underrun_d;

    logic boundary;
    logic stuff_pending;
    logic handshake;

    assign boundary      = (state_q != StIdle) && (cnt_q == CntMax);
    assign stuff_pending = boundary && (run_len_q == StuffRun) && stuff_en && en;

    always_comb begin
        din_ready = 1'b0;
        unique case (state_q)
            StIdle:          din_ready = en;
            StData, StStuff: din_ready = boundary && !stuff_pending && en;
            default:         din_ready = 1'b0;
        endcase
    end

    assign handshake = din_ready && din_valid;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        run_len_d      = run_len_q;
        last_bit_d     = last_bit_q;
        tx_d           = tx_q;
        bit_strobe_d   = 1'b0;
        stuff_active_d = stuff_active_q;
        underrun_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                cnt_d          = '0;
                tx_d           = 1'b1;
                stuff_active_d = 1'b0;
                if (handshake) begin
                    state_d      = StData;
                    tx_d         = din;
                    bit_strobe_d = 1'b1;
                    last_bit_d   = din;
                    run_len_d    = 3'd1;
                end
            end
            StData, StStuff: begin
                if (!boundary) begin
                    cnt_d = cnt_q + CntW'(1);
                end else begin
                    cnt_d = '0;
                    if (stuff_pending) begin
                        // Stuff bit opens a new run of its own polarity.
                        state_d        = StStuff;
                        tx_d           = ~last_bit_q;
                        stuff_active_d = 1'b1;
                        bit_strobe_d   = 1'b1;
                        last_bit_d     = ~last_bit_q;
                        run_len_d      = 3'd1;
                    end else if (!en) begin
                        state_d        = StIdle;
                        tx_d           = 1'b1;
                        stuff_active_d = 1'b0;
                    end else if (din_valid) begin
                        state_d        = StData;
                        tx_d           = din;
                        bit_strobe_d   = 1'b1;
                        stuff_active_d = 1'b0;
                        if ((din == last_bit_q) && stuff_en) begin
                            run_len_d = (run_len_q < StuffRun) ? run_len_q + 3'd1 : StuffRun;
                        end else begin
                            run_len_d  = 3'd1;
                            last_bit_d = din;
                        end
                    end else begin
                        underrun_d     = 1'b1;
                        state_d        = StIdle;
                        tx_d           = 1'b1;
                        stuff_active_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d        = StIdle;
                cnt_d          = '0;
                tx_d           = 1'b1;
                stuff_active_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            run_len_q      <= 3'd0;
            last_bit_q     <= 1'b1;
            tx_q           <= 1'b1;
            bit_strobe_q   <= 1'b0;
            stuff_active_q <= 1'b0;
            underrun_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            run_len_q      <= run_len_d;
            last_bit_q     <= last_bit_d;
            tx_q           <= tx_d;
            bit_strobe_q   <= bit_strobe_d;
            stuff_active_q <= stuff_active_d;
            underrun_q     <= underrun_d;
        end
    end

    assign tx           = tx_q;
    assign bit_strobe   = bit_strobe_q;
    assign stuff_active = stuff_active_q;
    assign underrun     = underrun_q;

endmodule

// File: tb/tb_can_tx_bit_stuffer.sv
// Scoreboard bench for can_tx_bit_stuffer: the driver queues hand-computed bit slots, a monitor
// checks every bit_strobe against them, including exact bit spacing and hold.
module tb_can_tx_bit_stuffer;

    localparam int unsigned CLKS = 100;

    logic clk = 1'b0;
    logic rst_n, en, stuff_en, din, din_valid;
    logic din_ready, tx, bit_strobe, stuff_active, underrun;

    can_tx_bit_stuffer #(
        .clk_speed_MHz(100),
        .can_bit_rate_Kbits(1000)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .en(en),
        .stuff_en(stuff_en),
        .din(din),
        .din_valid(din_valid),
        .din_ready(din_ready),
        .tx(tx),
        .bit_strobe(bit_strobe),
        .stuff_active(stuff_active),
        .underrun(underrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        tx;
        logic        stuff;
        int unsigned gap;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   n_underrun = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: compare each transmitted bit with the queued slot, and flag any tx/stuff_active
    // change that is not a bit start or the end of a full final bit.
    int unsigned gap_cnt = 0;
    logic        prev_tx = 1'b1;
    logic        prev_st = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            gap_cnt = 0;
        end else begin
            gap_cnt++;
            if (underrun) n_underrun++;
            if (bit_strobe) begin
                check("sb_nonempty", (exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("bit_tx", tx, e.tx);
                    check("bit_stuff", stuff_active, e.stuff);
                    if (e.gap != 0) check("bit_gap", gap_cnt, e.gap);
                end
                gap_cnt = 0;
            end else if (tx !== prev_tx || stuff_active !== prev_st) begin
                check("bit_hold", {29'd0, (gap_cnt == CLKS), tx, stuff_active}, 32'b110);
            end
        end
        prev_tx = tx;
        prev_st = stuff_active;
    end

    // bits/etx/est are read left to right: bit n-1 goes first.
    task automatic feed(input logic [15:0] bits, input int n, input logic [15:0] etx,
                        input logic [15:0] est, input int ne, input logic se,
                        input logic keep_en);
        exp_t e;
        for (int i = 0; i < ne; i++) begin
            e.tx    = etx[ne-1-i];
            e.stuff = est[ne-1-i];
            e.gap   = (i == 0) ? 0 : CLKS;
            exp_q.push_back(e);
        end
        en       = 1'b1;
        stuff_en = se;
        for (int i = 0; i < n; i++) begin
            int t;
            din       = bits[n-1-i];
            din_valid = 1'b1;
            #1;
            t = 0;
            while (!din_ready && t < 3 * CLKS) begin
                @(negedge clk);
                t++;
            end
            check("din_ready_wait", din_ready, 1);
            @(posedge clk);
            #1;
        end
        din_valid = 1'b0;
        if (!keep_en) en = 1'b0;
        repeat (CLKS) @(negedge clk);
        check("tail_hold", tx, etx[0]);
        @(negedge clk);
        check("tail_idle_tx", tx, 1);
        check("tail_idle_stuff", stuff_active, 0);
        check("tail_ready", din_ready, keep_en);
        check("tail_underrun", underrun, keep_en);
        if (keep_en) begin
            @(negedge clk);
            check("underrun_single", underrun, 0);
            check("ready_after_underrun", din_ready, 1);
            en = 1'b0;
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        rst_n     = 1'b0;
        en        = 1'b0;
        stuff_en  = 1'b0;
        din       = 1'b1;
        din_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_ready", din_ready, 0);
        check("idle_strobe", bit_strobe, 0);
        check("idle_underrun", underrun, 0);
        check("idle_tx", tx, 1);
        check("idle_stuff", stuff_active, 0);

        // Async reset in the middle of a dominant bit.
        e.tx = 1'b0; e.stuff = 1'b0; e.gap = 0;
        exp_q.push_back(e);
        en = 1'b1; stuff_en = 1'b1; din = 1'b0; din_valid = 1'b1;
        #1;
        check("idle_ready_en", din_ready, 1);
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        repeat (50) @(negedge clk);
        check("mid_bit_tx", tx, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_tx", tx, 1);
        check("async_rst_strobe", bit_strobe, 0);
        en = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", din_ready, 0);
        check("post_rst_tx", tx, 1);
        check("post_rst_underrun", underrun, 0);

        feed(16'b010, 3, 16'b010, 16'b000, 3, 1'b1, 1'b0);
        feed(16'b000001, 6, 16'b0000011, 16'b0000010, 7, 1'b1, 1'b0);
        feed(16'b0000011110, 10, 16'b000001111100, 16'b000001000010, 12, 1'b1, 1'b0);
        feed(16'b0000000, 7, 16'b0000000, 16'b0000000, 7, 1'b0, 1'b0);
        // Five equal bits with en dropped: the pending stuff bit is discarded.
        feed(16'b00000, 5, 16'b00000, 16'b00000, 5, 1'b1, 1'b0);
        feed(16'b111111, 6, 16'b1111101, 16'b0000010, 7, 1'b1, 1'b0);
        feed(16'b010, 3, 16'b010, 16'b000, 3, 1'b1, 1'b1);

        repeat (5) @(negedge clk);
        check("sb_drained", exp_q.size(), 0);
        check("underrun_count", n_underrun, 1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
